// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART: parity modes, FSM encodings, divisor floor
// and the parity/divisor helpers used by both the TX and RX paths.
package uart_fifo_pkg;

    localparam logic [1:0]  PARITY_NONE = 2'd0;
    localparam logic [1:0]  PARITY_ODD  = 2'd1;
    localparam logic [1:0]  PARITY_EVEN = 2'd2;
    localparam logic [15:0] MIN_DIV     = 16'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_PUSH   = 3'd5,
        RX_BREAK  = 3'd6
    } rx_state_e;

    // Data narrower than 8 bits is zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
        case (mode)
            PARITY_ODD:  return ~^data;
            PARITY_EVEN: return ^data;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// Byte-stream side of the UART: TX valid/ready, RX FIFO head/valid/ready,
// occupancy and overrun status.
interface uart_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8
);
    logic [DATA_BITS-1:0]      tx_byte;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [DATA_BITS-1:0]      rx_byte;
    logic                      rx_frame_err;
    logic                      rx_parity_err;
    logic                      rx_valid;
    logic                      rx_ready;
    logic [$clog2(DEPTH):0]    rx_count;
    logic                      overrun;
    logic                      clear_overrun;

    modport master (
        output tx_byte, tx_valid, rx_ready, clear_overrun,
        input  tx_ready, rx_byte, rx_frame_err, rx_parity_err, rx_valid, rx_count, overrun
    );

    modport slave (
        input  tx_byte, tx_valid, rx_ready, clear_overrun,
        output tx_ready, rx_byte, rx_frame_err, rx_parity_err, rx_valid, rx_count, overrun
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; a push into a full FIFO only
// lands when a pop frees the head slot on the same edge.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write, no reset needed on data.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/uart_fifo.sv
// Full-duplex UART with run-time divisor; received frames and their error
// flags are queued in an RX FIFO toward the on-chip byte stream.
module uart_fifo import uart_fifo_pkg::*; #(
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] divisor,
    input  logic        serial_rx,
    output logic        serial_tx,
    uart_fifo_if.slave  bus
);
    localparam logic [1:0] PAR_MODE   = 2'(PARITY);
    localparam logic       HAS_PARITY = (PARITY != 0);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam int         FW         = DATA_BITS + 2;

    logic [15:0] div_eff_s;
    assign div_eff_s = clamp_div(divisor);

    tx_state_e            tx_state_r, tx_state_s;
    logic [15:0]          tx_timer_r, tx_timer_s, tx_div_r, tx_div_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic [3:0]           tx_bit_r, tx_bit_s;
    logic                 tx_par_r, tx_par_s, serial_tx_r, serial_tx_s, tx_ready_r, tx_tick_s;

    assign tx_tick_s    = (tx_timer_r == 16'd0);
    assign serial_tx    = serial_tx_r;
    assign bus.tx_ready = tx_ready_r;

    // TX next-state: every bit lasts tx_div_r cycles, timer reloads on tick.
    always_comb begin
        tx_state_s  = tx_state_r;
        tx_timer_s  = tx_tick_s ? (tx_div_r - 16'd1) : (tx_timer_r - 16'd1);
        tx_div_s    = tx_div_r;
        tx_shift_s  = tx_shift_r;
        tx_bit_s    = tx_bit_r;
        tx_par_s    = tx_par_r;
        serial_tx_s = serial_tx_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (bus.tx_valid) begin
                    tx_state_s  = TX_START;
                    tx_div_s    = div_eff_s;
                    tx_timer_s  = div_eff_s - 16'd1;
                    tx_shift_s  = bus.tx_byte;
                    tx_par_s    = calc_parity(8'(bus.tx_byte), PAR_MODE);
                    tx_bit_s    = 4'd0;
                    serial_tx_s = 1'b0;
                end else begin
                    tx_timer_s  = tx_timer_r;
                    serial_tx_s = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick_s) begin
                    tx_state_s  = TX_DATA;
                    serial_tx_s = tx_shift_r[0];
                    tx_shift_s  = tx_shift_r >> 1;
                end else begin
                    tx_state_s  = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_tick_s) begin
                    if (tx_bit_r == LAST_DATA) begin
                        tx_bit_s = 4'd0;
                        if (HAS_PARITY) begin
                            tx_state_s  = TX_PARITY;
                            serial_tx_s = tx_par_r;
                        end else begin
                            tx_state_s  = TX_STOP;
                            serial_tx_s = 1'b1;
                        end
                    end else begin
                        tx_bit_s    = tx_bit_r + 4'd1;
                        serial_tx_s = tx_shift_r[0];
                        tx_shift_s  = tx_shift_r >> 1;
                    end
                end else begin
                    tx_state_s = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_tick_s) begin
                    tx_state_s  = TX_STOP;
                    tx_bit_s    = 4'd0;
                    serial_tx_s = 1'b1;
                end else begin
                    tx_state_s  = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_tick_s) begin
                    if (tx_bit_r == LAST_STOP) begin
                        tx_state_s = TX_IDLE;
                    end else begin
                        tx_bit_s   = tx_bit_r + 4'd1;
                    end
                    serial_tx_s = 1'b1;
                end else begin
                    tx_state_s  = TX_STOP;
                end
            end
            default: begin
                tx_state_s  = TX_IDLE;
                serial_tx_s = 1'b1;
            end
        endcase
    end

    // TX state register; tx_ready mirrors the IDLE state one edge early.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_r  <= TX_IDLE;
            tx_timer_r  <= 16'd0;
            tx_div_r    <= MIN_DIV;
            tx_shift_r  <= '0;
            tx_bit_r    <= 4'd0;
            tx_par_r    <= 1'b0;
            serial_tx_r <= 1'b1;
            tx_ready_r  <= 1'b1;
        end else begin
            tx_state_r  <= tx_state_s;
            tx_timer_r  <= tx_timer_s;
            tx_div_r    <= tx_div_s;
            tx_shift_r  <= tx_shift_s;
            tx_bit_r    <= tx_bit_s;
            tx_par_r    <= tx_par_s;
            serial_tx_r <= serial_tx_s;
            tx_ready_r  <= (tx_state_s == TX_IDLE);
        end
    end

    rx_state_e            rx_state_r, rx_state_s;
    logic [15:0]          rx_timer_r, rx_timer_s, rx_div_r, rx_div_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
    logic [3:0]           rx_bit_r, rx_bit_s;
    logic                 rx_ferr_r, rx_ferr_s, rx_perr_r, rx_perr_s;
    logic                 rx_meta_r, rx_sync_r, rx_prev_r, rx_tick_s, rx_push_s;
    logic                 fifo_full_s, fifo_empty_s, overrun_r;
    logic [FW-1:0]        fifo_head_s;

    assign rx_tick_s = (rx_timer_r == 16'd0);
    assign rx_push_s = (rx_state_r == RX_PUSH);

    // RX next-state: first sample at half a bit, then one per bit centre.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_timer_s = rx_tick_s ? (rx_div_r - 16'd1) : (rx_timer_r - 16'd1);
        rx_div_s   = rx_div_r;
        rx_shift_s = rx_shift_r;
        rx_bit_s   = rx_bit_r;
        rx_ferr_s  = rx_ferr_r;
        rx_perr_s  = rx_perr_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_state_s = RX_START;
                    rx_div_s   = div_eff_s;
                    rx_timer_s = (div_eff_s >> 1) - 16'd1;
                    rx_bit_s   = 4'd0;
                    rx_ferr_s  = 1'b0;
                    rx_perr_s  = 1'b0;
                end else begin
                    rx_timer_s = rx_timer_r;
                end
            end
            RX_START: begin
                if (rx_tick_s) begin
                    rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bit_r == LAST_DATA) begin
                        rx_bit_s   = 4'd0;
                        rx_state_s = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_s   = rx_bit_r + 4'd1;
                    end
                end else begin
                    rx_state_s = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_tick_s) begin
                    rx_perr_s  = (rx_sync_r != calc_parity(8'(rx_shift_r), PAR_MODE));
                    rx_state_s = RX_STOP;
                end else begin
                    rx_state_s = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_tick_s) begin
                    rx_ferr_s = rx_ferr_r | ~rx_sync_r;
                    if (rx_bit_r == LAST_STOP) begin
                        rx_state_s = RX_PUSH;
                    end else begin
                        rx_bit_s   = rx_bit_r + 4'd1;
                    end
                end else begin
                    rx_state_s = RX_STOP;
                end
            end
            // A line still low after the stop sample is a break: hold off re-arming.
            RX_PUSH:  rx_state_s = rx_sync_r ? RX_IDLE : RX_BREAK;
            RX_BREAK: rx_state_s = rx_sync_r ? RX_IDLE : RX_BREAK;
            default:  rx_state_s = RX_IDLE;
        endcase
    end

    // RX synchronizer and state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_timer_r <= 16'd0;
            rx_div_r   <= MIN_DIV;
            rx_shift_r <= '0;
            rx_bit_r   <= 4'd0;
            rx_ferr_r  <= 1'b0;
            rx_perr_r  <= 1'b0;
        end else begin
            rx_meta_r  <= serial_rx;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            rx_state_r <= rx_state_s;
            rx_timer_r <= rx_timer_s;
            rx_div_r   <= rx_div_s;
            rx_shift_r <= rx_shift_s;
            rx_bit_r   <= rx_bit_s;
            rx_ferr_r  <= rx_ferr_s;
            rx_perr_r  <= rx_perr_s;
        end
    end

    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push_s),
        .push_data ({rx_shift_r, rx_ferr_r, rx_perr_r}),
        .pop       (bus.rx_ready),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (bus.rx_count)
    );

    assign bus.rx_byte       = fifo_head_s[FW-1:2];
    assign bus.rx_frame_err  = fifo_head_s[1];
    assign bus.rx_parity_err = fifo_head_s[0];
    assign bus.rx_valid      = ~fifo_empty_s;
    assign bus.overrun       = overrun_r;

    // Sticky overrun; a new loss wins over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (rx_push_s && fifo_full_s && !bus.rx_ready) begin
            overrun_r <= 1'b1;
        end else if (bus.clear_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench: a no-parity instance for the raw TX waveform, and an
// even-parity instance for loopback, error frames, FIFO, divisor and reset.
module tb_uart_fifo;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] div_np, div_ev;
    logic        tx_np, tx_ev, rx_line_ev, drv_rx, loop_en;
    int          check_cnt = 0;
    int          error_cnt = 0;

    uart_fifo_if #(.DATA_BITS(8), .DEPTH(8)) bus_np ();
    uart_fifo_if #(.DATA_BITS(8), .DEPTH(8)) bus_ev ();

    assign rx_line_ev = loop_en ? tx_ev : drv_rx;

    uart_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(8)) u_dut_np (
        .clock(clock), .reset(reset), .divisor(div_np),
        .serial_rx(1'b1), .serial_tx(tx_np), .bus(bus_np)
    );

    uart_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(8)) u_dut_ev (
        .clock(clock), .reset(reset), .divisor(div_ev),
        .serial_rx(rx_line_ev), .serial_tx(tx_ev), .bus(bus_ev)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_ev(input logic [7:0] b);
        int n;
        n = 0;
        while (!bus_ev.tx_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check_val("send_rdy", 32'(bus_ev.tx_ready), 32'd1);
        bus_ev.tx_byte  = b;
        bus_ev.tx_valid = 1'b1;
        @(negedge clock);
        bus_ev.tx_valid = 1'b0;
    endtask

    // Counts tx_ready-low cycles from the accept edge; optionally retargets divisor.
    task automatic measure_ev(input int change_at, input logic [15:0] new_div, output int low);
        low = 0;
        while (!bus_ev.tx_ready && low < 1000) begin
            if (low == change_at) div_ev = new_div;
            low++;
            @(negedge clock);
        end
    endtask

    task automatic drive_frame(input logic [7:0] data, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drv_rx = bits[i];
            tick(8);
        end
        drv_rx = 1'b1;
        tick(8);
    endtask

    task automatic wait_count(input logic [3:0] target);
        int n;
        n = 0;
        while (bus_ev.rx_count != target && n < 2000) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] b, input logic fe, input logic pe);
        int n;
        n = 0;
        while (!bus_ev.rx_valid && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check_val({tag, "_valid"}, 32'(bus_ev.rx_valid), 32'd1);
        check_val({tag, "_data"},  32'(bus_ev.rx_byte), 32'(b));
        check_val({tag, "_ferr"},  32'(bus_ev.rx_frame_err), 32'(fe));
        check_val({tag, "_perr"},  32'(bus_ev.rx_parity_err), 32'(pe));
        bus_ev.rx_ready = 1'b1;
        @(negedge clock);
        bus_ev.rx_ready = 1'b0;
    endtask

    initial begin
        logic [9:0] exp1;
        logic [7:0] b;
        int         low;

        reset = 1'b1; div_np = 16'd8; div_ev = 16'd8; drv_rx = 1'b1; loop_en = 1'b0;
        bus_np.tx_byte = 8'h00; bus_np.tx_valid = 1'b0; bus_np.rx_ready = 1'b0; bus_np.clear_overrun = 1'b0;
        bus_ev.tx_byte = 8'h00; bus_ev.tx_valid = 1'b0; bus_ev.rx_ready = 1'b0; bus_ev.clear_overrun = 1'b0;
        tick(3);
        check_val("rst_tx",     32'(tx_ev), 32'd1);
        check_val("rst_ready",  32'(bus_ev.tx_ready), 32'd1);
        check_val("rst_valid",  32'(bus_ev.rx_valid), 32'd0);
        check_val("rst_count",  32'(bus_ev.rx_count), 32'd0);
        check_val("rst_ovr",    32'(bus_ev.overrun), 32'd0);
        check_val("rst_tx_np",  32'(tx_np), 32'd1);
        reset = 1'b0;
        tick(2);

        // Raw waveform of 0xA5, no parity: start, LSB-first data, stop.
        exp1 = {1'b1, 8'hA5, 1'b0};
        bus_np.tx_byte = 8'hA5; bus_np.tx_valid = 1'b1;
        @(negedge clock);
        bus_np.tx_valid = 1'b0;
        low = 0;
        for (int k = 0; k < 80; k++) begin
            check_val("t1_tx", 32'(tx_np), 32'(exp1[k/8]));
            if (!bus_np.tx_ready) low++;
            @(negedge clock);
        end
        check_val("t1_low",  32'(low), 32'd80);
        check_val("t1_rdy",  32'(bus_np.tx_ready), 32'd1);
        check_val("t1_idle", 32'(tx_np), 32'd1);

        // Loopback with even parity.
        loop_en = 1'b1;
        send_ev(8'h00);
        send_ev(8'hFF);
        send_ev(8'h3C);
        wait_count(4'd3);
        check_val("t2_count", 32'(bus_ev.rx_count), 32'd3);
        pop_check("t2_b0", 8'h00, 1'b0, 1'b0);
        pop_check("t2_b1", 8'hFF, 1'b0, 1'b0);
        pop_check("t2_b2", 8'h3C, 1'b0, 1'b0);
        tick(20);
        loop_en = 1'b0;

        // 0x5A has four ones, so the correct even parity bit is 0.
        drive_frame(8'h5A, 1'b1, 1'b1);
        pop_check("t3_par", 8'h5A, 1'b0, 1'b1);
        drive_frame(8'h33, 1'b0, 1'b0);
        pop_check("t3_frm", 8'h33, 1'b1, 1'b0);
        drv_rx = 1'b0;
        tick(2);
        drv_rx = 1'b1;
        tick(100);
        check_val("t3_glitch", 32'(bus_ev.rx_count), 32'd0);
        drv_rx = 1'b0;
        tick(160);
        check_val("t3_brk_cnt", 32'(bus_ev.rx_count), 32'd1);
        drv_rx = 1'b1;
        tick(40);
        check_val("t3_brk_one", 32'(bus_ev.rx_count), 32'd1);
        pop_check("t3_brk", 8'h00, 1'b1, 1'b0);

        // Nine frames into an eight-deep FIFO with no pops.
        for (int i = 0; i < 9; i++) begin
            b = 8'h10 + 8'(i);
            drive_frame(b, ^b, 1'b1);
        end
        check_val("t4_count", 32'(bus_ev.rx_count), 32'd8);
        check_val("t4_ovr",   32'(bus_ev.overrun), 32'd1);
        check_val("t4_head",  32'(bus_ev.rx_byte), 32'h10);
        for (int i = 0; i < 8; i++) begin
            pop_check("t4_pop", 8'h10 + 8'(i), 1'b0, 1'b0);
        end
        check_val("t4_empty", 32'(bus_ev.rx_valid), 32'd0);
        check_val("t4_ovr_held", 32'(bus_ev.overrun), 32'd1);
        bus_ev.clear_overrun = 1'b1;
        @(negedge clock);
        bus_ev.clear_overrun = 1'b0;
        check_val("t4_ovr_clr", 32'(bus_ev.overrun), 32'd0);

        // 11-bit frames: 88 cycles at DIV=8, 176 at 16, 44 when 2 clamps to 4.
        send_ev(8'h55);
        measure_ev(20, 16'd16, low);
        check_val("t5_cur", 32'(low), 32'd88);
        send_ev(8'h55);
        measure_ev(-1, 16'd16, low);
        check_val("t5_next", 32'(low), 32'd176);
        div_ev = 16'd2;
        send_ev(8'h55);
        measure_ev(-1, 16'd2, low);
        check_val("t5_clamp", 32'(low), 32'd44);
        div_ev = 16'd8;

        // Reset with one frame queued and another in flight on both paths.
        loop_en = 1'b1;
        send_ev(8'hC3);
        wait_count(4'd1);
        check_val("t6_pre", 32'(bus_ev.rx_count), 32'd1);
        send_ev(8'h96);
        tick(40);
        check_val("t6_mid", 32'(tx_ev == 1'b0 || bus_ev.tx_ready == 1'b0), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_val("t6_tx",    32'(tx_ev), 32'd1);
        check_val("t6_rdy",   32'(bus_ev.tx_ready), 32'd1);
        check_val("t6_count", 32'(bus_ev.rx_count), 32'd0);
        reset = 1'b0;
        tick(300);
        check_val("t6_nopush", 32'(bus_ev.rx_count), 32'd0);
        check_val("t6_idle",   32'(tx_ev), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end
endmodule
